// File: rtl/ram_frame_reader_pkg.sv
// Shared types and constants for the frame RAM port-B reader.
// Holds the address/data/length widths, the sequencer state enum and the output FIFO entry type.
package ram_frame_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 16;

    localparam logic [LEN_W-1:0] LEN_MAX = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

endpackage

// File: rtl/ram_frame_fifo.sv
// Synchronous FIFO for the frame reader output stream, with occupancy count and flush.
// Head entry is presented directly from storage; flush has priority over push and pop.
module ram_frame_fifo
    import ram_frame_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  fifo_entry_t                i_wdata,
    input  logic                       i_pop,
    output fifo_entry_t                o_rdata,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fifo_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_do_push = i_push && !i_flush && !o_full;
    assign w_do_pop  = i_pop && !i_flush && !o_empty;

    // Pointer and occupancy tracking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Entry storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_cnt   = r_cnt;

    ram_frame_fifo_chk u_chk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_push),
        .i_flush (i_flush),
        .i_full  (o_full)
    );

endmodule

// File: rtl/ram_frame_fifo_chk.sv
// Simulation-only checker for the reader output FIFO.
// Flags any push that arrives while the FIFO is full and not being flushed.
module ram_frame_fifo_chk (
    input logic i_clk,
    input logic i_rst_n,
    input logic i_push,
    input logic i_flush,
    input logic i_full
);

    a_no_push_when_full : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && !i_flush && i_full));

endmodule

// File: rtl/ram_frame_reader.sv
// Port-B read sequencer: streams LEN bytes from BASE_ADDR of the frame RAM as a valid/ready stream.
// Optional RAM_FRAME_READER_CSUM_EN adds o_csum, the modulo-256 sum of bytes transferred this frame.
module ram_frame_reader
    import ram_frame_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_wen,
    input  logic [DATA_W-1:0] i_ram_dout,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_dout_vld,
    output logic              o_dout_last,
    input  logic              i_dout_rdy,
    output logic              o_busy,
`ifdef RAM_FRAME_READER_CSUM_EN
    output logic              o_done,
    output logic [DATA_W-1:0] o_csum
`else
    output logic              o_done
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int INF_W = $clog2(RD_LAT + 2);
    localparam int SUM_W = $clog2(FIFO_DEPTH + RD_LAT + 3);

    if (FIFO_DEPTH < RD_LAT + 2) begin : g_depth_chk
        $error("ram_frame_reader: FIFO_DEPTH must be >= RD_LAT+2");
    end

    state_t            r_state;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_rem;
    logic              r_busy;
    logic              r_done;
    logic [RD_LAT:0]   r_tag_vld;
    logic [RD_LAT:0]   r_tag_last;

    logic [CNT_W-1:0]  w_fifo_cnt;
    logic [INF_W-1:0]  w_inflight;
    logic [SUM_W-1:0]  w_used;
    logic              w_credit_ok;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_flush;
    logic              w_accept;
    logic              w_issue;
    logic [LEN_W-1:0]  w_len_c;
    fifo_entry_t       w_head;
    fifo_entry_t       w_wdata;

    assign w_len_c  = clamp_len(i_len);
    assign w_pop    = !w_empty && i_dout_rdy;
    assign w_accept = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_flush  = i_abort && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign w_issue  = (r_state == ST_RUN) && !i_abort && w_credit_ok && (r_rem != '0);
    assign w_wdata  = '{last: r_tag_last[RD_LAT], data: i_ram_dout};

    // Credit check: the entry leaving this cycle frees its slot, keeping 1 byte/cycle with a 4-deep FIFO
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i <= RD_LAT; i++) begin
            w_inflight = w_inflight + INF_W'(r_tag_vld[i]);
        end
        w_used      = SUM_W'(w_fifo_cnt) + SUM_W'(w_inflight);
        w_credit_ok = (w_used < (SUM_W'(FIFO_DEPTH) + SUM_W'(w_pop)));
    end

    ram_frame_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (w_flush),
        .i_push  (r_tag_vld[RD_LAT]),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_cnt   (w_fifo_cnt)
    );

    // Sequencer FSM, read address generation and in-flight tag pipeline
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_ram_addr <= '0;
            r_cur_addr <= '0;
            r_rem      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_tag_vld  <= '0;
            r_tag_last <= '0;
        end else begin
            r_done     <= 1'b0;
            r_tag_vld  <= {r_tag_vld[RD_LAT-1:0], 1'b0};
            r_tag_last <= {r_tag_last[RD_LAT-1:0], 1'b0};
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        if (w_len_c == '0) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            // First read goes out on the accept edge to hit the 4-cycle latency
                            r_ram_addr    <= i_base_addr;
                            r_cur_addr    <= i_base_addr + ADDR_W'(1);
                            r_rem         <= w_len_c - LEN_W'(1);
                            r_tag_vld[0]  <= 1'b1;
                            r_tag_last[0] <= (w_len_c == LEN_W'(1));
                            r_state       <= (w_len_c == LEN_W'(1)) ? ST_DRAIN : ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_abort) begin
                        r_tag_vld <= '0;
                        r_state   <= ST_FIN;
                        r_done    <= 1'b1;
                    end else if (w_issue) begin
                        r_ram_addr    <= r_cur_addr;
                        r_cur_addr    <= r_cur_addr + ADDR_W'(1);
                        r_rem         <= r_rem - LEN_W'(1);
                        r_tag_vld[0]  <= 1'b1;
                        r_tag_last[0] <= (r_rem == LEN_W'(1));
                        if (r_rem == LEN_W'(1)) r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (i_abort) begin
                        r_tag_vld <= '0;
                        r_state   <= ST_FIN;
                        r_done    <= 1'b1;
                    end else if (w_pop && w_head.last) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wen   = 1'b0;
    assign o_dout      = w_head.data;
    assign o_dout_vld  = !w_empty;
    assign o_dout_last = !w_empty && w_head.last;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

`ifdef RAM_FRAME_READER_CSUM_EN
    logic [DATA_W-1:0] r_csum;

    // Running modulo-256 sum of bytes accepted downstream
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csum <= '0;
        end else if (w_accept) begin
            r_csum <= '0;
        end else if (w_pop) begin
            r_csum <= r_csum + w_head.data;
        end
    end

    assign o_csum = r_csum;
`endif

endmodule

// File: tb/tb_ram_frame_reader.sv
// Directed self-checking bench for ram_frame_reader with a two-stage registered RAM model.
// Define RAM_FRAME_READER_CSUM_EN to also check the running checksum output.
module tb_ram_frame_reader;

    localparam int MAX_CYC = 2000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [14:0] base_addr;
    logic [15:0] len;
    logic        abort;
    logic [14:0] ram_addr;
    logic        ram_wen;
    logic [7:0]  ram_dout;
    logic [7:0]  dout;
    logic        dout_vld;
    logic        dout_last;
    logic        dout_rdy;
    logic        busy;
    logic        done;
`ifdef RAM_FRAME_READER_CSUM_EN
    logic [7:0]  csum;
`endif

    logic [7:0]  mem [0:32767];
    logic [7:0]  ram_q1;

    int          n_tests;
    int          n_fail;
    logic [8:0]  got_q [$];
    int          first_vld;
    int          done_cyc;
    int          abort_cyc;
    logic [14:0] addr_at [0:31];

    ram_frame_reader dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .i_len       (len),
        .i_abort     (abort),
        .o_ram_addr  (ram_addr),
        .o_ram_wen   (ram_wen),
        .i_ram_dout  (ram_dout),
        .o_dout      (dout),
        .o_dout_vld  (dout_vld),
        .o_dout_last (dout_last),
        .i_dout_rdy  (dout_rdy),
        .o_busy      (busy),
`ifdef RAM_FRAME_READER_CSUM_EN
        .o_done      (done),
        .o_csum      (csum)
`else
        .o_done      (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port B: address register plus output register gives two cycles of read latency
    always @(posedge clk) begin
        ram_q1   <= mem[ram_addr];
        ram_dout <= ram_q1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int pct);
        return (int'($urandom_range(99, 0)) < pct);
    endfunction

    task automatic run_frame(input string name, input logic [14:0] base, input logic [15:0] flen,
                             input int rdy_pct, input int abort_after, input int restart_cyc);
        int          ntx;
        int          exp_n;
        bit          prev_hold;
        logic [7:0]  prev_data;
        logic        prev_last;
        logic [7:0]  sum;
        logic [14:0] a;
        got_q.delete();
        first_vld = -1;
        done_cyc  = -1;
        abort_cyc = -1;
        ntx       = 0;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        prev_last = 1'b0;
        sum       = 8'h00;
        for (int i = 0; i < 32; i++) addr_at[i] = 15'h0000;
        for (int cyc = 0; cyc < MAX_CYC && done_cyc < 0; cyc++) begin
            @(posedge clk); #1;
            start     = (cyc == 0) || (cyc == restart_cyc);
            base_addr = (cyc == 0) ? base : 15'h0500;
            len       = (cyc == 0) ? flen : 16'd3;
            abort     = 1'b0;
            if (abort_after >= 0 && abort_cyc < 0 && ntx == abort_after) begin
                abort     = 1'b1;
                abort_cyc = cyc;
            end
            dout_rdy = abort ? 1'b0 : pick(rdy_pct);
            @(negedge clk);
            if (cyc < 32) addr_at[cyc] = ram_addr;
            if (prev_hold) begin
                check({name, "_hold_vld"},  32'(dout_vld),  32'd1);
                check({name, "_hold_data"}, 32'(dout),      32'(prev_data));
                check({name, "_hold_last"}, 32'(dout_last), 32'(prev_last));
            end
            if (dout_vld && first_vld < 0) first_vld = cyc;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                check({name, "_vld_after_abort"}, 32'(dout_vld), 32'd0);
            end
            if (dout_vld && dout_rdy) begin
                got_q.push_back({dout_last, dout});
                ntx++;
                sum = sum + dout;
            end
            prev_hold = dout_vld && !dout_rdy && !abort;
            prev_data = dout;
            prev_last = dout_last;
            if (done) begin
                done_cyc = cyc;
                check({name, "_busy_at_done"}, 32'(busy), 32'd1);
`ifdef RAM_FRAME_READER_CSUM_EN
                check({name, "_csum_at_done"}, 32'(csum), 32'(sum));
`endif
            end
        end
        start    = 1'b0;
        abort    = 1'b0;
        check({name, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
        exp_n = (abort_cyc >= 0) ? abort_after : int'(flen);
        check({name, "_count"}, 32'(got_q.size()), 32'(exp_n));
        for (int i = 0; i < got_q.size() && i < exp_n; i++) begin
            a = base + 15'(i);
            check($sformatf("%s_data%0d", name, i), 32'(got_q[i][7:0]), 32'(mem[a]));
            check($sformatf("%s_last%0d", name, i), 32'(got_q[i][8]),
                  32'((abort_cyc < 0) && (i == exp_n - 1)));
        end
        @(posedge clk); #1;
        @(negedge clk);
        check({name, "_busy_after"}, 32'(busy),     32'd0);
        check({name, "_done_after"}, 32'(done),     32'd0);
        check({name, "_vld_after"},  32'(dout_vld), 32'd0);
        check({name, "_wen"},        32'(ram_wen),  32'd0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = 15'h0000;
        len       = 16'd0;
        dout_rdy  = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 8'(i);
        mem[512] = 8'hFF;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_addr", 32'(ram_addr),  32'd0);
        check("rst_ram_wen",  32'(ram_wen),   32'd0);
        check("rst_dout",     32'(dout),      32'd0);
        check("rst_vld",      32'(dout_vld),  32'd0);
        check("rst_last",     32'(dout_last), 32'd0);
        check("rst_busy",     32'(busy),      32'd0);
        check("rst_done",     32'(done),      32'd0);
        rst_n = 1'b1;

        // basic frame: 0x10..0x17, first valid 4 cycles after START, DONE after LAST
        run_frame("basic", 15'h0010, 16'd8, 100, -1, -1);
        check("basic_first_vld", 32'(first_vld), 32'd4);
        check("basic_done_cyc",  32'(done_cyc),  32'd12);

        // address wrap at the top of the RAM
        run_frame("wrap", 15'h7FFE, 16'd4, 100, -1, -1);
        check("wrap_addr0", 32'(addr_at[1]), 32'h7FFE);
        check("wrap_addr1", 32'(addr_at[2]), 32'h7FFF);
        check("wrap_addr2", 32'(addr_at[3]), 32'h0000);
        check("wrap_addr3", 32'(addr_at[4]), 32'h0001);

        // heavy backpressure
        run_frame("bp", 15'h1234, 16'd64, 30, -1, -1);

        // zero length: DONE in the only busy cycle, no stream
        run_frame("len0", 15'h0000, 16'd0, 100, -1, -1);
        check("len0_done_cyc", 32'(done_cyc),      32'd1);
        check("len0_no_vld",   32'(first_vld < 0), 32'd1);

        // abort after ten transfers, then a clean short frame
        run_frame("abort", 15'h0300, 16'd100, 100, 10, -1);
        check("abort_done_cyc", 32'(done_cyc), 32'(abort_cyc + 1));
        run_frame("post_abort", 15'h0020, 16'd2, 100, -1, -1);

        // START while busy is ignored
        run_frame("restart", 15'h0040, 16'd6, 100, -1, 3);
        check("restart_done_cyc", 32'(done_cyc), 32'd10);

        // checksum wraps modulo 256
        run_frame("csum", 15'h0200, 16'd4, 100, -1, -1);
`ifdef RAM_FRAME_READER_CSUM_EN
        check("csum_value", 32'(csum), 32'h05);
`endif

        // ABORT wins over START in IDLE
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; base_addr = 15'h0000; len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_done", 32'(done), 32'd0);

        // asynchronous reset mid-frame
        @(posedge clk); #1;
        start = 1'b1; base_addr = 15'h0000; len = 16'd20; dout_rdy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy",     32'(busy),     32'd0);
        check("arst_vld",      32'(dout_vld), 32'd0);
        check("arst_ram_addr", 32'(ram_addr), 32'd0);
        check("arst_done",     32'(done),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post_rst", 15'h0100, 16'd2, 100, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_frame_reader.md
Name: ram_frame_reader

Overview:
- Port-B read sequencer for the 32K x 8 dual-port frame RAM; the RAM wrapper adds an output register, giving a total read latency of RD_LAT = 2 cycles.
- On START it reads LEN bytes from BASE_ADDR and emits them as a valid/ready byte stream with a LAST marker.
- A credit-based output FIFO absorbs the RAM read latency so backpressure never loses data.
- Sits between the RAM port B and the downstream framer/transmitter.

Parameters:
- ADDR_W, 15, RAM address width (32K locations).
- DATA_W, 8, data width.
- LEN_W, 16, frame length width; legal LEN range is 0..32768.
- RD_LAT, 2, cycles from RAM_ADDR to valid RAM_DOUT.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+2 (checked at elaboration).

Ports:
- CLK  in  1  single clock, shared with RAM port B clock.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle request pulse; ignored while BUSY=1.
- BASE_ADDR  in  ADDR_W  first address, sampled on accepted START.
- LEN  in  LEN_W  byte count, sampled on accepted START.
- ABORT  in  1  terminate current frame.
- RAM_ADDR  out  ADDR_W  to RAM B_ADDR, registered.
- RAM_WEN  out  1  to RAM B_WEN; constant 0 (read-only port).
- RAM_DOUT  in  DATA_W  from RAM B_DOUT.
- DOUT  out  DATA_W  stream data.
- DOUT_VLD  out  1  stream valid.
- DOUT_LAST  out  1  marks the final byte of the frame.
- DOUT_RDY  in  1  downstream ready.
- BUSY  out  1  high from accepted START until the DONE cycle, inclusive.
- DONE  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: RAM_ADDR=0, RAM_WEN=0, DOUT=0, DOUT_VLD=0, DOUT_LAST=0, BUSY=0, DONE=0. FIFO and all counters are cleared; state is IDLE.
- State machine: IDLE -> RUN -> DRAIN -> FIN -> IDLE.
- IDLE:
  - START with LEN>0 latches BASE_ADDR and LEN, sets BUSY, and enters RUN.
  - START with LEN=0 goes directly to FIN (BUSY=1 for one cycle, DONE=1 in that same cycle, no stream output).
- RUN:
  - Issue one read per cycle when fifo_cnt + inflight < FIFO_DEPTH.
  - An issued read drives RAM_ADDR = cur_addr; cur_addr increments modulo 2^ADDR_W (0x7FFF wraps to 0x0000).
  - After LEN reads have been issued, go to DRAIN.
- Inflight tracking:
  - A shift register of depth RD_LAT tags issued reads.
  - A tagged RAM_DOUT is written into the FIFO exactly RD_LAT cycles after issue.
  - The last-byte tag travels with the data into the FIFO.
- Output:
  - DOUT, DOUT_VLD and DOUT_LAST come from the FIFO head.
  - A transfer occurs when DOUT_VLD && DOUT_RDY.
  - DOUT, DOUT_VLD and DOUT_LAST must hold stable while DOUT_VLD && !DOUT_RDY.
- DRAIN: when inflight=0 and the FIFO is empty after the LAST transfer, go to FIN.
- FIN: DONE=1 for one cycle, BUSY still 1; next cycle is IDLE with BUSY=0.
- Latency: with DOUT_RDY held high, the first DOUT_VLD appears 4 cycles after the START cycle (1 address register + RD_LAT + 1 FIFO). Sustained throughput is 1 byte per cycle.
- Simultaneous FIFO push and pop in the same cycle: the count is unchanged. Push to a full FIFO is impossible by construction; assert this in simulation.
- ABORT (any non-IDLE state):
  - Stop issuing reads and flush the FIFO.
  - Discard in-flight returns; their tags are cleared.
  - DOUT_VLD drops the next cycle.
  - Go to FIN and pulse DONE. DOUT_LAST is not emitted.
  - ABORT in IDLE is ignored. ABORT together with START in IDLE: ABORT wins and START is dropped.
- START while BUSY: ignored, and the latched parameters are unchanged.
- Reset mid-frame: all state clears immediately (asynchronously); no DONE pulse.
- LEN > 32768: clamp to 32768.

Optional Feature:
- Macro RAM_FRAME_READER_CSUM_EN.
- Defined:
  - Adds output CSUM [DATA_W-1:0]: modulo-256 sum of all bytes transferred on DOUT in the current frame.
  - CSUM is cleared on accepted START and valid while DONE=1.
  - An aborted frame reports the partial sum.
- Undefined: the CSUM port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package ram_frame_pkg holds:
  - ADDR_W, DATA_W and LEN_W constants;
  - the state enum (IDLE, RUN, DRAIN, FIN);
  - the FIFO entry typedef {last, data}.
- Natural sub-module: ram_frame_fifo, a synchronous FIFO with FIFO_DEPTH entries, count output and flush input. The FSM, address counter and inflight tracking stay in the top module.

Test Plan:
- BASE_ADDR=0x0010, LEN=8, RAM preloaded with addr[7:0], DOUT_RDY=1 -> bytes 0x10..0x17 on consecutive cycles; first DOUT_VLD 4 cycles after START; LAST on 0x17; DONE one cycle after that transfer.
- BASE_ADDR=0x7FFE, LEN=4 -> RAM_ADDR sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001; four bytes out in order.
- LEN=64, DOUT_RDY random at 30% high -> no loss or duplication, FIFO never overflows, stream stable while stalled, 64 bytes total with a single LAST.
- LEN=0 -> BUSY high for one cycle with DONE in that cycle; DOUT_VLD never asserts.
- LEN=100, ABORT after 10 transfers -> DOUT_VLD low the next cycle, no LAST, DONE pulse; a following START with LEN=2 streams correct data with no stale bytes.
- START pulsed again mid-frame with BASE_ADDR=0x0500 -> ignored; the original frame completes unchanged. With RAM_FRAME_READER_CSUM_EN defined, LEN=4 with data 0xFF,0x01,0x02,0x03 -> CSUM=0x05 at DONE.
